// File: rtl/mem_key_checker_if.sv
// Bus bundle between the key checker and its environment: key stream,
// reference key, external comparator operands/results and attempt status.
interface mem_key_checker_if #(
  parameter int NIBBLES  = 4,
  parameter int MAX_FAIL = 3
);
  logic [3:0]                      key_in;
  logic                            key_valid;
  logic                            key_ready;
  logic [4*NIBBLES-1:0]            ref_key;
  logic [3:0]                      cmp_a;
  logic [3:0]                      cmp_b;
  logic                            cmp_c;
  logic                            cmp_d;
  logic                            cmp_e;
  logic                            done;
  logic                            grant;
  logic                            deny;
  logic                            locked;
  logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
  logic                            cmp_err;

  modport master (
    output key_in, key_valid, ref_key, cmp_c, cmp_d, cmp_e,
    input  key_ready, cmp_a, cmp_b, done, grant, deny, locked, fail_cnt, cmp_err
  );

  modport slave (
    input  key_in, key_valid, ref_key, cmp_c, cmp_d, cmp_e,
    output key_ready, cmp_a, cmp_b, done, grant, deny, locked, fail_cnt, cmp_err
  );
endinterface

// File: rtl/mem_key_checker.sv
// Nibble-serial key checker using an external 4-bit comparator, with
// consecutive-failure counting and a timed lockout.
module mem_key_checker #(
  parameter int NIBBLES     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_key_checker_if.slave  bus
);
  localparam int KW = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT, LOCK} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic            mismatch;
  logic            err;
  logic [FW-1:0]   fail_cnt;
  logic [FW-1:0]   fail_inc;
  logic [CW-1:0]   lock_cnt;
  logic [KW-1:0]   shadow;
  logic [3:0]      cmp_a, cmp_b;
  logic            accept;
  logic            last_nib;
  logic            onehot_bad;
  logic            key_ready, done, grant, deny, locked;

  assign accept     = (state == IDLE) && !rst && bus.key_valid;
  assign last_nib   = (idx == LAST_IDX);
  assign onehot_bad = ({1'b0, bus.cmp_c} + {1'b0, bus.cmp_d} + {1'b0, bus.cmp_e}) != 2'd1;
  assign fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    done      = 1'b0;
    grant     = 1'b0;
    deny      = 1'b0;
    locked    = 1'b0;
    case (state)
      IDLE: begin
        key_ready = !rst;
        if (accept) state_nxt = CHECK;
      end
      CHECK: state_nxt = last_nib ? REPORT : IDLE;
      REPORT: begin
        done  = 1'b1;
        grant = !mismatch;
        deny  = mismatch;
        if (mismatch && (fail_inc == FAIL_MAX)) state_nxt = LOCK;
        else                                     state_nxt = IDLE;
      end
      LOCK: begin
        locked = 1'b1;
        // Counter is loaded with LOCK_CYCLES and leaves as it reaches zero,
        // so locked stays high for exactly LOCK_CYCLES clocks.
        if (lock_cnt <= CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      mismatch <= 1'b0;
      err      <= 1'b0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      shadow   <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmp_a <= bus.key_in;
            // First nibble bypasses the shadow so the snapshot and operand
            // come from the same ref_key sample.
            if (idx == '0) begin
              shadow <= bus.ref_key;
              cmp_b  <= bus.ref_key[3:0];
            end else begin
              cmp_b  <= shadow[{idx, 2'b00} +: 4];
            end
          end
        end
        CHECK: begin
          if (!bus.cmp_d || onehot_bad) mismatch <= 1'b1;
          if (onehot_bad)               err      <= 1'b1;
          if (!last_nib)                idx      <= idx + IW'(1);
        end
        REPORT: begin
          idx      <= '0;
          mismatch <= 1'b0;
          err      <= 1'b0;
          fail_cnt <= mismatch ? fail_inc : '0;
          if (state_nxt == LOCK) lock_cnt <= CW'(LOCK_CYCLES);
        end
        LOCK: begin
          lock_cnt <= lock_cnt - CW'(1);
          if (state_nxt == IDLE) fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.cmp_a     = cmp_a;
  assign bus.cmp_b     = cmp_b;
  assign bus.done      = done;
  assign bus.grant     = grant;
  assign bus.deny      = deny;
  assign bus.locked    = locked;
  assign bus.fail_cnt  = fail_cnt;
  assign bus.cmp_err   = err;
endmodule

// File: tb/tb_mem_key_checker.sv
// Scoreboard bench for mem_key_checker: attempts push expected outcome and
// done cycle; a negedge monitor pops and checks them, plus fail_cnt/lock.
module tb_mem_key_checker;
  localparam int NIB = 4;
  localparam int MF  = 3;
  localparam int LC  = 16;

  logic clk;
  logic rst;
  logic force_err;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic grant;
    logic deny;
    logic err;
    int   cyc;
  } exp_t;
  exp_t q[$];

  mem_key_checker_if #(.NIBBLES(NIB), .MAX_FAIL(MF)) bus ();

  mem_key_checker #(.NIBBLES(NIB), .MAX_FAIL(MF), .LOCK_CYCLES(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External comparator; force_err makes A<B and A=B both true.
  always_comb begin
    bus.cmp_c = bus.cmp_a < bus.cmp_b;
    bus.cmp_d = bus.cmp_a == bus.cmp_b;
    bus.cmp_e = bus.cmp_a > bus.cmp_b;
    if (force_err) begin
      bus.cmp_c = 1'b1;
      bus.cmp_d = 1'b1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on done, fail_cnt/locked checked one clock later.
  int   exp_fail;
  logic pend;
  logic prev_locked;
  initial begin
    exp_fail    = 0;
    pend        = 1'b0;
    prev_locked = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_fail = 0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        chk("fail_cnt", 32'(bus.fail_cnt), 32'(exp_fail));
        chk("locked_after_done", 32'(bus.locked), 32'(exp_fail == MF));
        pend = 1'b0;
      end
      if (prev_locked && !bus.locked) exp_fail = 0;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("grant", 32'(bus.grant), 32'(e.grant));
          chk("deny", 32'(bus.deny), 32'(e.deny));
          chk("cmp_err", 32'(bus.cmp_err), 32'(e.err));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.deny) exp_fail = (exp_fail >= MF) ? MF : exp_fail + 1;
          else        exp_fail = 0;
          pend = 1'b1;
        end
      end
    end
    prev_locked = bus.locked;
  end

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic send_nib(input logic [3:0] n, input int gap, input bit err_here, output int hs_cyc);
    int t = 0;
    while (!bus.key_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.key_ready) chk("ready_timeout", 32'd0, 32'd1);
    if (gap > 0) begin
      bus.key_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.key_in    = n;
    bus.key_valid = 1'b1;
    force_err     = err_here;
    hs_cyc        = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic attempt(input logic [15:0] key, input bit err2, input bit gaps, input bit ref_change);
    int   g[NIB];
    int   total = 0;
    int   hs;
    int   t = 0;
    exp_t e;
    logic [15:0] ref0 = bus.ref_key;
    for (int i = 0; i < NIB; i++) begin
      g[i]  = (gaps && i > 0) ? int'($urandom_range(1, 3)) : 0;
      total += g[i];
    end
    for (int i = 0; i < NIB; i++) begin
      send_nib(key[i*4 +: 4], g[i], err2 && (i == 2), hs);
      if (i == 0) begin
        e.grant = (key == ref0) && !err2;
        e.deny  = !e.grant;
        e.err   = err2;
        e.cyc   = hs + 2 * NIB + total;
        q.push_back(e);
        if (ref_change) bus.ref_key = '0;
      end
    end
    bus.key_valid = 1'b0;
    force_err     = 1'b0;
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int hs;
    int lk;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    force_err     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.ref_key   = 16'hA5C3;

    repeat (3) @(negedge clk);
    chk("rst_key_ready", 32'(bus.key_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
    chk("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_key_ready", 32'(bus.key_ready), 32'd1);
    @(negedge clk);

    attempt(16'hA5C3, 1'b0, 1'b0, 1'b0);  // grant
    attempt(16'hB5C3, 1'b0, 1'b0, 1'b0);  // deny, fail 1
    attempt(16'hA5C3, 1'b0, 1'b0, 1'b0);  // grant clears fail
    attempt(16'hA5C3, 1'b1, 1'b0, 1'b0);  // comparator fault -> deny
    attempt(16'hA5C3, 1'b0, 1'b0, 1'b0);
    attempt(16'h15C3, 1'b0, 1'b0, 1'b0);
    attempt(16'hA5C4, 1'b0, 1'b0, 1'b0);
    attempt(16'h0000, 1'b0, 1'b0, 1'b0);  // third deny -> lockout

    // Lockout: key_valid held high must be ignored throughout.
    bus.key_valid = 1'b1;
    bus.key_in    = 4'h3;
    @(negedge clk);
    lk = 0;
    while (bus.locked && lk < 100) begin
      chk("lock_key_ready", 32'(bus.key_ready), 32'd0);
      lk++;
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    chk("lock_len", 32'(lk), 32'(LC));
    chk("unlock_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("unlock_key_ready", 32'(bus.key_ready), 32'd1);
    @(negedge clk);

    // Reset mid-attempt after two accepted nibbles.
    send_nib(4'h3, 0, 1'b0, hs);
    send_nib(4'hC, 0, 1'b0, hs);
    bus.key_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_deny", 32'(bus.deny), 32'd0);
    chk("mid_rst_cmp_a", 32'(bus.cmp_a), 32'd0);
    chk("mid_rst_cmp_b", 32'(bus.cmp_b), 32'd0);
    chk("mid_rst_cmp_err", 32'(bus.cmp_err), 32'd0);
    chk("mid_rst_key_ready", 32'(bus.key_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", 32'(bus.key_ready), 32'd1);
    attempt(16'hA5C3, 1'b0, 1'b0, 1'b0);

    // Gaps plus ref_key change after the first nibble.
    @(negedge clk);
    attempt(16'hA5C3, 1'b0, 1'b1, 1'b1);
    bus.ref_key = 16'hA5C3;
    @(negedge clk);
    attempt(16'hA5C3, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_key_checker.md
MEM_KEY_CHECKER -- requirements
Module: mem_key_checker

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit key nibbles per access attempt.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, giving the consecutive denied attempts that trigger lockout.
REQ-003 The block SHALL have parameter LOCK_CYCLES, default 16, giving the lockout duration in clocks.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 key_in  in  4  candidate key nibble, least-significant nibble first.
REQ-008 key_valid  in  1  key_in valid.
REQ-009 key_ready  out  1  block accepts a nibble.
REQ-010 ref_key  in  4*NIBBLES  stored reference key.
REQ-011 cmp_a  out  4  registered operand A to the external 4-bit comparator.
REQ-012 cmp_b  out  4  registered operand B to the external 4-bit comparator.
REQ-013 cmp_c, cmp_d, cmp_e  in  1 each  comparator results A<B, A=B, A>B.
REQ-014 done  out  1  one-cycle pulse, attempt finished.
REQ-015 grant  out  1  one-cycle pulse with done, key matched.
REQ-016 deny  out  1  one-cycle pulse with done, key mismatched.
REQ-017 locked  out  1  high throughout lockout.
REQ-018 fail_cnt  out  clog2(MAX_FAIL+1)  consecutive denied attempts.
REQ-019 cmp_err  out  1  sticky for the current attempt, comparator result not one-hot.

Function
REQ-020 The FSM SHALL have four states: IDLE, CHECK, REPORT and LOCK.
REQ-021 key_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, on key_valid && key_ready the block SHALL register cmp_a <= key_in, register cmp_b <= shadow nibble [idx*4 +: 4], and go to CHECK.
REQ-023 On the handshake with idx==0, ref_key SHALL be captured into the shadow register, with cmp_b taken directly from ref_key; later changes to ref_key SHALL not affect the current attempt.
REQ-024 In CHECK the block SHALL sample cmp_c/cmp_d/cmp_e (combinational from cmp_a/cmp_b) and act as follows:
  - !cmp_d: set sticky mismatch.
  - (cmp_c+cmp_d+cmp_e)!=1: set cmp_err and mismatch.
  - idx==NIBBLES-1: go to REPORT.
  - otherwise: idx++ and return to IDLE.
REQ-025 Minimum throughput SHALL be one nibble per 2 clocks; key_valid gaps SHALL only stall IDLE.
REQ-026 With key_valid held high and the first handshake at cycle 0, REPORT SHALL occur at cycle 2*NIBBLES.
REQ-027 In REPORT the block SHALL assert done for exactly one cycle, with grant=!mismatch and deny=mismatch.
REQ-028 At REPORT exit, idx, mismatch and cmp_err SHALL clear.
REQ-029 On grant, fail_cnt SHALL clear to 0.
REQ-030 On deny, fail_cnt SHALL increment, saturating at MAX_FAIL.
REQ-031 If a deny brings fail_cnt to MAX_FAIL, the next state SHALL be LOCK; otherwise it SHALL be IDLE.
REQ-032 In LOCK, locked=1, key_ready=0, and a down-counter loaded with LOCK_CYCLES SHALL run; at count 0 the block SHALL clear fail_cnt, deassert locked and enter IDLE.
REQ-033 key_valid during LOCK or CHECK SHALL be ignored and no nibble consumed.
REQ-034 cmp_a and cmp_b SHALL hold their values outside the handshake cycle.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL enter IDLE, and SHALL force the following to 0: idx, mismatch, cmp_err, fail_cnt, lock counter, cmp_a, cmp_b, done, grant, deny, locked.
REQ-036 key_ready SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-037 Reset mid-attempt SHALL discard all partial state with no done pulse.

Verification
REQ-038 ref_key=16'hA5C3; send nibbles 3,C,5,A with key_valid constant -> done=grant=1 at cycle 8, deny=0, fail_cnt=0.
REQ-039 ref_key=16'hA5C3; send 3,C,5,B -> done=deny=1 at cycle 8, fail_cnt=1.
REQ-040 Three consecutive wrong attempts -> third deny, then locked=1 and key_ready=0 for 16 cycles while key_valid=1 is ignored; afterwards fail_cnt=0 and key_ready=1.
REQ-041 Comparator model forced to cmp_c=cmp_d=1 on nibble 2 of a correct key -> cmp_err=1 and deny=1.
REQ-042 Assert rst after 2 accepted nibbles -> all outputs 0 the next cycle, no done pulse; the next full correct key -> grant.
REQ-043 Insert random 1-3 cycle key_valid gaps, change ref_key mid-attempt to 16'h0000 -> grant against the original 16'hA5C3, with REPORT delayed by exactly the total gap cycles.
